// File: rtl/aes128_inverse_cipher.sv
// aes128_inverse_cipher: iterative AES-128 decryption, one inverse round per clock.
// Starts from the round-10 key and derives k9..k0 on the fly using the inverse key schedule.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   ciphertext + key_last handshake (in_ready high only in IDLE)
//   ct, key_last        128-bit ciphertext and round-10 key, byte 0 in [127:120], column-major
//   out_valid/out_ready plaintext handshake, pt held stable until out_ready
//   pt                  recovered plaintext
//   busy                high while a block is in ROUND or DONE
//   key0                recovered cipher key k0 (only when AES_DEC_KEY_OUT_EN is defined)
module aes128_inverse_cipher (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt,
    output logic         busy
`ifdef AES_DEC_KEY_OUT_EN
    ,
    output logic [127:0] key0
`endif
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t       fsm, nxt;
    logic [127:0] st, rk, nk, sr, t, mc;
    logic [3:0]   rnd;
    logic [31:0]  nw1, nw2, nw3, sw;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xt(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, s;
        r = 8'h01;
        s = a;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = ginv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] s);
        return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    // InvMixColumns matrix is circulant: coefficient depends only on (k - j) mod 4.
    function automatic logic [7:0] coef(input logic [1:0] d);
        return d == 2'd0 ? 8'h0e : d == 2'd1 ? 8'h0b : d == 2'd2 ? 8'h0d : 8'h09;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        nw3 = rk[31:0] ^ rk[63:32];
        nw2 = rk[63:32] ^ rk[95:64];
        nw1 = rk[95:64] ^ rk[127:96];
        // SubWord(RotWord(w3')) of the previous round key
        sw  = {sbox(nw3[23:16]), sbox(nw3[15:8]), sbox(nw3[7:0]), sbox(nw3[31:24])};
        nk  = {rk[127:96] ^ sw ^ {rcon(rnd), 24'h0}, nw1, nw2, nw3};
        sr  = '0;
        mc  = '0;
        // Row r rotates right by r: output column c takes input column (c - r) mod 4.
        for (int i = 0; i < 16; i++)
            sr[127-8*i -: 8] = isbox(st[127-8*((i%4) + 4*(((i/4) - (i%4)) & 3)) -: 8]);
        t = sr ^ nk;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 4; k++)
                    mc[127-8*(4*c+j) -: 8] = mc[127-8*(4*c+j) -: 8] ^ gmul(coef(2'(k - j)), t[127-8*(4*c+k) -: 8]);
    end

    always_comb begin
        nxt = fsm;
        if (fsm == IDLE && in_valid) nxt = ROUND;
        else if (fsm == ROUND && rnd == 4'd1) nxt = DONE;
        else if (fsm == DONE && out_ready) nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm <= IDLE;
            st  <= '0;
            rk  <= '0;
            rnd <= '0;
        end else begin
            fsm <= nxt;
            if (fsm == IDLE && in_valid) begin
                st  <= ct ^ key_last;
                rk  <= key_last;
                rnd <= 4'd10;
            end else if (fsm == ROUND) begin
                st  <= rnd == 4'd1 ? t : mc;
                rk  <= nk;
                rnd <= rnd - 4'd1;
            end
        end
    end

`ifdef AES_DEC_KEY_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) key0 <= '0;
        else if (fsm == ROUND) key0 <= nk;
    end
`endif

    assign in_ready  = fsm == IDLE;
    assign out_valid = fsm == DONE;
    assign busy      = fsm != IDLE;
    assign pt        = st;
endmodule
